sbit_pattern_gen: RTL
=====================

SBIT_PATTERN_GEN -- requirements
Module: sbit_pattern_gen

Interface
REQ-001 Parameter NUM_VFATS, default 24: number of VFATs driven, each with 8 trigger units (TUs).
REQ-002 Parameter DDR, default 0: 0 gives FRAME_BITS=8 serial bits per TU per BX; 1 gives 16.
REQ-003 Derived constant PAT_W = 8*FRAME_BITS: pattern word width, 64 or 128.
REQ-004 ttc_clk_40_i  in  1  40 MHz logic clock; the only clock.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 bc0_i  in  1  bunch-crossing-zero strobe.
REQ-007 start_i  in  1  run request pulse.
REQ-008 stop_i  in  1  abort request pulse.
REQ-009 sync_bc0_i  in  1  when 1, a run starts only on bc0_i.
REQ-010 mode_i  in  2  pattern mode: 0 even/odd, 1 walking-one, 2 PRBS7, 3 zeros.
REQ-011 pattern_even_i, pattern_odd_i  in  PAT_W each  fixed patterns.
REQ-012 burst_len_i  in  4  pattern BXs per burst, minus 1.
REQ-013 gap_len_i  in  8  idle BXs between bursts; 0 means back-to-back bursts.
REQ-014 repeat_i  in  8  number of bursts; 0 means run until stop_i.
REQ-015 tu_invert_i  in  NUM_VFATS*8 and sot_invert_i  in  NUM_VFATS  per-pin polarity masks.
REQ-016 sbits_o  out  NUM_VFATS*8*FRAME_BITS  parallel frames; sot_o  out  NUM_VFATS*FRAME_BITS.
REQ-017 busy_o, done_o  out  1 each  status.

Function
REQ-018 The FSM SHALL have states IDLE, ARM, BURST, GAP.
REQ-019 IDLE→ARM on start_i; start_i is ignored in any other state.
REQ-020 ARM→BURST next cycle when sync_bc0_i=0; when sync_bc0_i=1, ARM→BURST on the cycle bc0_i=1.
REQ-021 BURST lasts burst_len_i+1 BXs.
REQ-022 At the end of a burst: to GAP if gap_len_i>0, else straight to the next BURST, else to IDLE when the burst count is reached.
REQ-023 GAP lasts gap_len_i BXs, then returns to BURST or IDLE.
REQ-024 The burst counter SHALL count completed bursts; the run ends when it equals repeat_i and repeat_i≠0.
REQ-025 stop_i in any non-IDLE state forces IDLE next cycle; stop_i and start_i in the same cycle: stop wins and no run starts.
REQ-026 done_o pulses one cycle on entry to IDLE from a run, both on normal end and on stop.
REQ-027 busy_o=1 in ARM, BURST and GAP.
REQ-028 Raw pattern word per BX, PAT_W bits:
- BURST, mode 0: pattern_even_i on even burst BX index, pattern_odd_i on odd (index restarts each burst).
- BURST, mode 1: single one; bit 0 on the first BX of a run, rotated left by 1 each BURST BX, wrapping from PAT_W-1 to 0.
- BURST, mode 3: zeros.
- ARM, GAP, IDLE: zeros.
REQ-029 TU t of every VFAT SHALL take word bits [t*FRAME_BITS +: FRAME_BITS], MSB transmitted first.
REQ-030 Each sot_o frame SHALL be 1 in bit FRAME_BITS-1 and 0 elsewhere, every BX after reset, independent of FSM state.
REQ-031 Each sbits_o bit SHALL be XORed with its tu_invert_i bit; each sot_o frame SHALL be XORed with its sot_invert_i bit replicated.
REQ-032 Outputs SHALL be registered; the first pattern frame appears on sbits_o one cycle after the FSM enters BURST.

Reset
REQ-033 reset_i SHALL force IDLE and clear all counters, the walking-one register and the PRBS state, whether or not a run is in progress.
REQ-034 During reset, sbits_o, sot_o, busy_o and done_o SHALL be 0, with no inversion applied.
REQ-035 Polarity masks SHALL take effect from the first cycle after reset_i is released.

Configuration
REQ-036 With SBIT_PRBS_EN defined, mode 2 SHALL output a PRBS7 stream (x^7+x^6+1, seed 7'h7F at run start), advanced PAT_W steps per BURST BX, first generated bit in word bit PAT_W-1.
REQ-037 Without SBIT_PRBS_EN, mode 2 SHALL behave as mode 3 and no LFSR logic is synthesised.

Structure
REQ-038 A shared package sbit_pkg SHALL hold the FSM state enum, the mode encodings and the FRAME_BITS/PAT_W derivation functions.
REQ-039 The PRBS7 word generator SHALL be a sub-module, prbs7_word_gen, parametrised by PAT_W.

Verification
REQ-040 SDR, mode 0, even=64'h1, odd=64'h2, burst_len=1, gap=6, repeat=2: VFAT0 TU0 frames 8'h01 then 8'h02, then 6 zero BXs, repeated once, then done_o pulses.
REQ-041 sync_bc0_i=1, start_i 100 cycles before bc0_i: busy_o=1 throughout; first frame appears one cycle after the BX following bc0_i.
REQ-042 Mode 1, repeat=0, burst_len=15, gap=0: the single one walks through bits 0..63 and wraps to bit 0 on the 65th BX; stop_i returns to IDLE next cycle with done_o=1.
REQ-043 tu_invert_i of VFAT0 = 8'h45, sot_invert_i=1, while idle: TU0/2/6 frames = 8'hFF, other TUs = 8'h00, sot_o frame = 8'h7F.
REQ-044 Reset asserted mid-burst: all outputs 0 on the next cycle, and a fresh start_i restarts the even pattern at index 0.
REQ-045 DDR=1 with SBIT_PRBS_EN: 128-bit words match a reference PRBS7 model; with the macro undefined, mode 2 outputs zeros.

Source files
------------

// File: rtl/sbit_pkg.sv
// Shared types and width helpers for the S-bit pattern generator.
package sbit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_BURST = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_EVEN_ODD = 2'd0,
    MODE_WALK     = 2'd1,
    MODE_PRBS7    = 2'd2,
    MODE_ZERO     = 2'd3
  } mode_e;

  localparam int unsigned TUS_PER_VFAT = 8;
  localparam logic [6:0]  PRBS7_SEED   = 7'h7F;

  function automatic int unsigned frame_bits(input int unsigned ddr);
    return (ddr != 0) ? 16 : 8;
  endfunction

  function automatic int unsigned pat_width(input int unsigned ddr);
    return TUS_PER_VFAT * frame_bits(ddr);
  endfunction

endpackage

// File: rtl/sbit_pattern_gen_prbs.sv
// PRBS7 (x^7+x^6+1) word generator: PAT_W steps per call, first bit in the MSB.
// Only compiled when SBIT_PRBS_EN is defined, so no LFSR exists otherwise.
`ifdef SBIT_PRBS_EN
module prbs7_word_gen #(
  parameter int unsigned PAT_W = 64
) (
  input  logic [6:0]       state,
  output logic [PAT_W-1:0] word_c,
  output logic [6:0]       state_nxt_c
);

  always_comb begin
    logic [6:0] s;
    logic       fb;
    word_c      = '0;
    state_nxt_c = '0;
    s           = state;
    fb          = 1'b0;
    // Shift each new bit in at the LSB so the earliest bit lands in the MSB.
    for (int i = 0; i < int'(PAT_W); i++) begin
      fb     = s[6] ^ s[5];
      word_c = {word_c[PAT_W-2:0], fb};
      s      = {s[5:0], fb};
    end
    state_nxt_c = s;
  end

endmodule
`endif

// File: rtl/sbit_pattern_gen.sv
// Trigger-unit S-bit pattern generator: burst/gap sequencer feeding all VFAT frames.
// Define SBIT_PRBS_EN to enable the PRBS7 mode; otherwise mode 2 outputs zeros.
module sbit_pattern_gen
  import sbit_pkg::*;
#(
  parameter  int unsigned NUM_VFATS  = 24,
  parameter  int unsigned DDR        = 0,
  localparam int unsigned FRAME_BITS = frame_bits(DDR),
  localparam int unsigned PAT_W      = pat_width(DDR)
) (
  input  logic                                       ttc_clk_40_i,
  input  logic                                       reset_i,
  input  logic                                       bc0_i,
  input  logic                                       start_i,
  input  logic                                       stop_i,
  input  logic                                       sync_bc0_i,
  input  logic [1:0]                                 mode_i,
  input  logic [PAT_W-1:0]                           pattern_even_i,
  input  logic [PAT_W-1:0]                           pattern_odd_i,
  input  logic [3:0]                                 burst_len_i,
  input  logic [7:0]                                 gap_len_i,
  input  logic [7:0]                                 repeat_i,
  input  logic [NUM_VFATS*TUS_PER_VFAT-1:0]          tu_invert_i,
  input  logic [NUM_VFATS-1:0]                       sot_invert_i,
  output logic [NUM_VFATS*TUS_PER_VFAT*FRAME_BITS-1:0] sbits_o,
  output logic [NUM_VFATS*FRAME_BITS-1:0]            sot_o,
  output logic                                       busy_o,
  output logic                                       done_o
);

  localparam int unsigned NUM_TUS = NUM_VFATS * TUS_PER_VFAT;
  localparam logic [FRAME_BITS-1:0] SOT_FRAME = {1'b1, {(FRAME_BITS-1){1'b0}}};

  state_e                          state_q, state_nxt;
  logic [3:0]                      bx_cnt_q;
  logic [7:0]                      gap_cnt_q, burst_cnt_q;
  logic [PAT_W-1:0]                walk_q;
  logic                            burst_last_c, gap_last_c, run_end_c, gap_run_end_c;
  logic [PAT_W-1:0]                word_c;
  logic [NUM_TUS*FRAME_BITS-1:0]   sbits_c;
  logic [NUM_VFATS*FRAME_BITS-1:0] sot_c;

  assign burst_last_c  = (bx_cnt_q == burst_len_i);
  assign gap_last_c    = (gap_cnt_q == gap_len_i - 8'd1);
  assign run_end_c     = (repeat_i != 8'd0) && (8'(burst_cnt_q + 8'd1) == repeat_i);
  assign gap_run_end_c = (repeat_i != 8'd0) && (burst_cnt_q == repeat_i);

  always_ff @(posedge ttc_clk_40_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (start_i && !stop_i) state_nxt = ST_ARM;
      ST_ARM: begin
        if (stop_i)                       state_nxt = ST_IDLE;
        else if (!sync_bc0_i || bc0_i)    state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (stop_i)                       state_nxt = ST_IDLE;
        else if (burst_last_c) begin
          if (gap_len_i != 8'd0)          state_nxt = ST_GAP;
          else if (run_end_c)             state_nxt = ST_IDLE;
          else                            state_nxt = ST_BURST;
        end
      end
      ST_GAP: begin
        if (stop_i)                       state_nxt = ST_IDLE;
        else if (gap_last_c)              state_nxt = gap_run_end_c ? ST_IDLE : ST_BURST;
      end
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  // Counters and walking-one register; everything is re-seeded while armed.
  always_ff @(posedge ttc_clk_40_i) begin
    if (reset_i) begin
      bx_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      burst_cnt_q <= '0;
      walk_q      <= '0;
    end else begin
      case (state_q)
        ST_ARM: begin
          bx_cnt_q    <= '0;
          gap_cnt_q   <= '0;
          burst_cnt_q <= '0;
          walk_q      <= PAT_W'(1);
        end
        ST_BURST: begin
          walk_q <= {walk_q[PAT_W-2:0], walk_q[PAT_W-1]};
          if (burst_last_c) begin
            bx_cnt_q    <= '0;
            burst_cnt_q <= burst_cnt_q + 8'd1;
          end else begin
            bx_cnt_q <= bx_cnt_q + 4'd1;
          end
        end
        ST_GAP:  gap_cnt_q <= gap_last_c ? 8'd0 : gap_cnt_q + 8'd1;
        default: ;
      endcase
    end
  end

`ifdef SBIT_PRBS_EN
  logic [6:0]       prbs_q, prbs_nxt_c;
  logic [PAT_W-1:0] prbs_word_c;

  prbs7_word_gen #(.PAT_W(PAT_W)) u_prbs (
    .state       (prbs_q),
    .word_c      (prbs_word_c),
    .state_nxt_c (prbs_nxt_c)
  );

  always_ff @(posedge ttc_clk_40_i) begin
    if (reset_i)                  prbs_q <= '0;
    else if (state_q == ST_ARM)   prbs_q <= PRBS7_SEED;
    else if (state_q == ST_BURST) prbs_q <= prbs_nxt_c;
  end
`endif

  always_comb begin
    word_c = '0;
    if (state_q == ST_BURST) begin
      case (mode_e'(mode_i))
        MODE_EVEN_ODD: word_c = bx_cnt_q[0] ? pattern_odd_i : pattern_even_i;
        MODE_WALK:     word_c = walk_q;
`ifdef SBIT_PRBS_EN
        MODE_PRBS7:    word_c = prbs_word_c;
`endif
        default:       word_c = '0;
      endcase
    end
  end

  // Every VFAT carries the same word; polarity masks apply per pin.
  for (genvar v = 0; v < int'(NUM_VFATS); v++) begin : g_vfat
    assign sot_c[v*FRAME_BITS +: FRAME_BITS] = SOT_FRAME ^ {FRAME_BITS{sot_invert_i[v]}};
    for (genvar t = 0; t < int'(TUS_PER_VFAT); t++) begin : g_tu
      assign sbits_c[(v*TUS_PER_VFAT+t)*FRAME_BITS +: FRAME_BITS] =
        word_c[t*FRAME_BITS +: FRAME_BITS] ^ {FRAME_BITS{tu_invert_i[v*TUS_PER_VFAT+t]}};
    end
  end

  always_ff @(posedge ttc_clk_40_i) begin
    if (reset_i) begin
      sbits_o <= '0;
      sot_o   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      sbits_o <= sbits_c;
      sot_o   <= sot_c;
      busy_o  <= (state_nxt != ST_IDLE);
      done_o  <= (state_q != ST_IDLE) && (state_nxt == ST_IDLE);
    end
  end

endmodule
